// File: rtl/rc_arbiter.sv
// rc_arbiter
// Round-robin arbiter that lets two requesters share one combinational RC unit
// (AND / OR of two bits). A requester raises req with its operands; the
// arbiter latches the operands, drives them to the shared unit for SETTLE
// cycles, captures the unit's outputs into that requester's result
// registers, and pulses done for one cycle.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   req0, a0, b0        requester 0 request and operands
//   gnt0, done0         requester 0 owns the unit / result-updated pulse
//   z0, w0              requester 0 results (AND, OR)
//   req1 .. w1          same set for requester 1
//   rc_a, rc_b          operands driven to the shared RC unit
//   rc_z, rc_w          shared RC unit outputs (rc_a&rc_b, rc_a|rc_b)
//   busy                high whenever the arbiter is not idle
module rc_arbiter #(
   parameter int unsigned SETTLE = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic req0,
   input  logic a0,
   input  logic b0,
   output logic gnt0,
   output logic done0,
   output logic z0,
   output logic w0,
   input  logic req1,
   input  logic a1,
   input  logic b1,
   output logic gnt1,
   output logic done1,
   output logic z1,
   output logic w1,
   output logic rc_a,
   output logic rc_b,
   input  logic rc_z,
   input  logic rc_w,
   output logic busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Count value reached on the final GRANT cycle.
   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

   state_t     state;
   state_t     next_state;
   logic [3:0] cnt;
   logic [3:0] next_cnt;
   logic       last_served;
   logic       owner;
   logic       op_a;
   logic       op_b;
   logic       grant_now;
   logic       grant_sel;
   logic       capture;

   // State and settle-counter register. Reset drops straight back to IDLE so
   // an operation in flight is simply abandoned.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= next_state;
         cnt   <= next_cnt;
      end
   end

   // Next-state decode. On a tie the requester that was not served last wins,
   // which makes two continuously held requests alternate.
   always_comb begin
      next_state = state;
      next_cnt   = cnt;
      grant_now  = 1'b0;
      grant_sel  = 1'b0;
      capture    = 1'b0;
      case (state)
         IDLE: begin
            if (req0 || req1) begin
               grant_now  = 1'b1;
               grant_sel  = (req0 && req1) ? ~last_served : req1;
               next_state = GRANT;
               next_cnt   = 4'd0;
            end
         end
         GRANT: begin
            if (cnt == SETTLE_LAST) begin
               capture    = 1'b1;
               next_state = DONE;
               next_cnt   = 4'd0;
            end else begin
               next_cnt = cnt + 4'd1;
            end
         end
         DONE: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
            next_cnt   = 4'd0;
         end
      endcase
   end

   // Operand latch, owner tracking and per-requester result registers.
   // Operands are frozen at the grant edge so later changes on a*/b* cannot
   // disturb the operation; only the owner's results are ever written.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_served <= 1'b1;
         owner       <= 1'b0;
         op_a        <= 1'b0;
         op_b        <= 1'b0;
         z0          <= 1'b0;
         w0          <= 1'b0;
         z1          <= 1'b0;
         w1          <= 1'b0;
      end else begin
         if (grant_now) begin
            owner <= grant_sel;
            op_a  <= grant_sel ? a1 : a0;
            op_b  <= grant_sel ? b1 : b0;
         end
         if (capture) begin
            last_served <= owner;
            if (owner) begin
               z1 <= rc_z;
               w1 <= rc_w;
            end else begin
               z0 <= rc_z;
               w0 <= rc_w;
            end
         end
      end
   end

   // Outputs decode purely from registered state, so reset clears them
   // immediately without waiting for a clock edge.
   assign gnt0  = (state == GRANT) && !owner;
   assign gnt1  = (state == GRANT) &&  owner;
   assign done0 = (state == DONE)  && !owner;
   assign done1 = (state == DONE)  &&  owner;
   assign rc_a  = (state == GRANT) && op_a;
   assign rc_b  = (state == GRANT) && op_b;
   assign busy  = (state != IDLE);

endmodule

// File: tb/tb_rc_arbiter.sv
// tb_rc_arbiter
// Drives two arbiter instances (SETTLE=1 and SETTLE=3), each with a simple
// model of the shared RC unit. Expected results are queued when a request is
// issued; per-instance monitors pop and compare on every done pulse and also
// check that grants and done pulses never overlap.
module tb_rc_arbiter;

   typedef struct packed {
      logic id;
      logic z;
      logic w;
   } exp_t;

   logic clk;
   logic rst1_n, rst3_n;

   logic s1_req0, s1_a0, s1_b0, s1_gnt0, s1_done0, s1_z0, s1_w0;
   logic s1_req1, s1_a1, s1_b1, s1_gnt1, s1_done1, s1_z1, s1_w1;
   logic s1_rc_a, s1_rc_b, s1_rc_z, s1_rc_w, s1_busy;

   logic s3_req0, s3_a0, s3_b0, s3_gnt0, s3_done0, s3_z0, s3_w0;
   logic s3_req1, s3_a1, s3_b1, s3_gnt1, s3_done1, s3_z1, s3_w1;
   logic s3_rc_a, s3_rc_b, s3_rc_z, s3_rc_w, s3_busy;

   int   total = 0;
   int   bad   = 0;
   int   s1_done_cnt = 0;
   int   s3_done_cnt = 0;
   exp_t q1[$];
   exp_t q3[$];

   // Shared RC unit models.
   assign s1_rc_z = s1_rc_a & s1_rc_b;
   assign s1_rc_w = s1_rc_a | s1_rc_b;
   assign s3_rc_z = s3_rc_a & s3_rc_b;
   assign s3_rc_w = s3_rc_a | s3_rc_b;

   rc_arbiter #(.SETTLE(1)) dut1 (
      .clk(clk), .rst_n(rst1_n),
      .req0(s1_req0), .a0(s1_a0), .b0(s1_b0),
      .gnt0(s1_gnt0), .done0(s1_done0), .z0(s1_z0), .w0(s1_w0),
      .req1(s1_req1), .a1(s1_a1), .b1(s1_b1),
      .gnt1(s1_gnt1), .done1(s1_done1), .z1(s1_z1), .w1(s1_w1),
      .rc_a(s1_rc_a), .rc_b(s1_rc_b), .rc_z(s1_rc_z), .rc_w(s1_rc_w),
      .busy(s1_busy)
   );

   rc_arbiter #(.SETTLE(3)) dut3 (
      .clk(clk), .rst_n(rst3_n),
      .req0(s3_req0), .a0(s3_a0), .b0(s3_b0),
      .gnt0(s3_gnt0), .done0(s3_done0), .z0(s3_z0), .w0(s3_w0),
      .req1(s3_req1), .a1(s3_a1), .b1(s3_b1),
      .gnt1(s3_gnt1), .done1(s3_done1), .z1(s3_z1), .w1(s3_w1),
      .rc_a(s3_rc_a), .rc_b(s3_rc_b), .rc_z(s3_rc_z), .rc_w(s3_rc_w),
      .busy(s3_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Output snapshot, MSB first:
   // gnt0 gnt1 done0 done1 z0 w0 z1 w1 rc_a rc_b busy
   function automatic logic [10:0] s1_outs();
      return {s1_gnt0, s1_gnt1, s1_done0, s1_done1, s1_z0, s1_w0,
              s1_z1, s1_w1, s1_rc_a, s1_rc_b, s1_busy};
   endfunction

   function automatic logic [10:0] s3_outs();
      return {s3_gnt0, s3_gnt1, s3_done0, s3_done1, s3_z0, s3_w0,
              s3_z1, s3_w1, s3_rc_a, s3_rc_b, s3_busy};
   endfunction

   task automatic checkOutput(input string name, input logic [10:0] act,
                              input logic [10:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input bit sel3, input logic r0, a0, b0,
                                input logic r1, a1, b1);
      if (sel3) begin
         s3_req0 = r0; s3_a0 = a0; s3_b0 = b0;
         s3_req1 = r1; s3_a1 = a1; s3_b1 = b1;
      end else begin
         s1_req0 = r0; s1_a0 = a0; s1_b0 = b0;
         s1_req1 = r1; s1_a1 = a1; s1_b1 = b1;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor for the SETTLE=1 instance.
   always @(negedge clk) begin
      exp_t e;
      total++;
      if ((s1_gnt0 && s1_gnt1) || (s1_done0 && s1_done1)) begin
         bad++;
         $display("[TB] FAIL s1 exclusive: gnt=%b%b done=%b%b expected no overlap",
                  s1_gnt0, s1_gnt1, s1_done0, s1_done1);
      end
      if (s1_done0 || s1_done1) begin
         s1_done_cnt++;
         if (q1.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL s1 unexpected done: done=%b%b expected none",
                     s1_done0, s1_done1);
         end else begin
            e = q1.pop_front();
            checkOutput("s1 result id/z/w",
                        {8'd0, s1_done1, s1_done1 ? {s1_z1, s1_w1} : {s1_z0, s1_w0}},
                        {8'd0, e.id, e.z, e.w});
         end
      end
   end

   // Scoreboard monitor for the SETTLE=3 instance.
   always @(negedge clk) begin
      exp_t e;
      total++;
      if ((s3_gnt0 && s3_gnt1) || (s3_done0 && s3_done1)) begin
         bad++;
         $display("[TB] FAIL s3 exclusive: gnt=%b%b done=%b%b expected no overlap",
                  s3_gnt0, s3_gnt1, s3_done0, s3_done1);
      end
      if (s3_done0 || s3_done1) begin
         s3_done_cnt++;
         if (q3.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL s3 unexpected done: done=%b%b expected none",
                     s3_done0, s3_done1);
         end else begin
            e = q3.pop_front();
            checkOutput("s3 result id/z/w",
                        {8'd0, s3_done1, s3_done1 ? {s3_z1, s3_w1} : {s3_z0, s3_w0}},
                        {8'd0, e.id, e.z, e.w});
         end
      end
   end

   initial begin
      logic [1:0] pair_a [4];
      logic [1:0] pair_zw [4];
      logic       pz, pw, a, b;
      int         base;
      bit         seen;

      pair_a  = '{2'b00, 2'b01, 2'b10, 2'b11};
      pair_zw = '{2'b00, 2'b01, 2'b01, 2'b11};

      applyStimulus(1'b0, 0, 0, 0, 0, 0, 0);
      applyStimulus(1'b1, 0, 0, 0, 0, 0, 0);
      rst1_n = 1'b1;
      rst3_n = 1'b1;
      #1;
      rst1_n = 1'b0;
      rst3_n = 1'b0;
      #2;
      checkOutput("s1 reset state", s1_outs(), 11'b0);
      checkOutput("s3 reset state", s3_outs(), 11'b0);
      tick();
      rst1_n = 1'b1;
      rst3_n = 1'b1;
      tick();
      checkOutput("s1 idle no req", s1_outs(), 11'b0);

      // SETTLE=1 single request on requester 0, a0=1 b0=1.
      applyStimulus(1'b0, 1, 1, 1, 0, 0, 0);
      q1.push_back('{id: 1'b0, z: 1'b1, w: 1'b1});
      tick();
      checkOutput("t1 grant cycle", s1_outs(), 11'b10000000111);
      applyStimulus(1'b0, 0, 0, 0, 0, 0, 0);
      tick();
      checkOutput("t1 done cycle", s1_outs(), 11'b00101100001);
      tick();
      checkOutput("t1 back idle", s1_outs(), 11'b00001100000);

      // Requester 1 through all four operand pairs; requester 0 results held.
      pz = 1'b0;
      pw = 1'b0;
      for (int p = 0; p < 4; p++) begin
         a = pair_a[p][1];
         b = pair_a[p][0];
         applyStimulus(1'b0, 0, 0, 0, 1, a, b);
         q1.push_back('{id: 1'b1, z: pair_zw[p][1], w: pair_zw[p][0]});
         tick();
         applyStimulus(1'b0, 0, 0, 0, 0, 0, 0);
         checkOutput($sformatf("t2 pair%0d grant", p), s1_outs(),
                     {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, pz, pw, a, b, 1'b1});
         tick();
         checkOutput($sformatf("t2 pair%0d done", p), s1_outs(),
                     {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
                      pair_zw[p][1], pair_zw[p][0], 1'b0, 1'b0, 1'b1});
         pz = pair_zw[p][1];
         pw = pair_zw[p][0];
         tick();
         checkOutput($sformatf("t2 pair%0d idle", p), s1_outs(),
                     {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, pz, pw, 1'b0, 1'b0, 1'b0});
      end

      // Both requests held from reset release: grants must go 0,1,0,1.
      #2;
      rst1_n = 1'b0;
      #1;
      checkOutput("t3 async reset", s1_outs(), 11'b0);
      applyStimulus(1'b0, 1, 1, 0, 1, 1, 1);
      q1.push_back('{id: 1'b0, z: 1'b0, w: 1'b1});
      q1.push_back('{id: 1'b1, z: 1'b1, w: 1'b1});
      q1.push_back('{id: 1'b0, z: 1'b0, w: 1'b1});
      q1.push_back('{id: 1'b1, z: 1'b1, w: 1'b1});
      base = s1_done_cnt;
      tick();
      rst1_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (s1_done_cnt >= base + 4) begin
            seen = 1'b1;
            break;
         end
      end
      applyStimulus(1'b0, 0, 0, 0, 0, 0, 0);
      checkOutput("t3 four dones seen", {10'd0, seen}, 11'd1);
      tick();
      tick();
      checkOutput("t3 final results", s1_outs(), 11'b00000111000);

      // SETTLE=3, a0 toggled during GRANT must not matter.
      applyStimulus(1'b1, 1, 0, 1, 0, 0, 0);
      q3.push_back('{id: 1'b0, z: 1'b0, w: 1'b1});
      tick();
      checkOutput("t4 grant cycle 1", s3_outs(), 11'b10000000011);
      applyStimulus(1'b1, 0, 1, 1, 0, 0, 0);
      for (int i = 2; i <= 3; i++) begin
         tick();
         checkOutput($sformatf("t4 grant cycle %0d", i), s3_outs(), 11'b10000000011);
         s3_a0 = ~s3_a0;
      end
      tick();
      checkOutput("t4 done cycle", s3_outs(), 11'b00100100001);
      tick();
      checkOutput("t4 back idle", s3_outs(), 11'b00000100000);

      // Reset in the second GRANT cycle abandons the operation.
      applyStimulus(1'b1, 1, 1, 1, 0, 0, 0);
      tick();
      applyStimulus(1'b1, 0, 1, 1, 0, 0, 0);
      tick();
      checkOutput("t5 second grant cycle", s3_outs(), 11'b10000100111);
      #2;
      rst3_n = 1'b0;
      #1;
      checkOutput("t5 async reset mid-grant", s3_outs(), 11'b0);
      applyStimulus(1'b1, 1, 1, 1, 1, 0, 0);
      repeat (3) tick();
      checkOutput("t5 held in reset", s3_outs(), 11'b0);
      q3.push_back('{id: 1'b0, z: 1'b1, w: 1'b1});
      q3.push_back('{id: 1'b1, z: 1'b0, w: 1'b0});
      base = s3_done_cnt;
      rst3_n = 1'b1;
      tick();
      checkOutput("t5 tie grants 0 first", s3_outs(), 11'b10000000111);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (s3_done_cnt >= base + 2) begin
            seen = 1'b1;
            break;
         end
      end
      applyStimulus(1'b1, 0, 0, 0, 0, 0, 0);
      checkOutput("t5 two dones seen", {10'd0, seen}, 11'd1);
      tick();
      tick();
      checkOutput("t5 final results", s3_outs(), 11'b00001100000);

      repeat (2) tick();
      checkOutput("s1 queue drained", 11'(q1.size()), 11'd0);
      checkOutput("s3 queue drained", 11'(q3.size()), 11'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
